lsu_subword: RTL and testbench
==============================

Name: lsu_subword

Overview:
- Load/store unit that sits directly upstream of the word-only data memory, between the MEM pipeline stage and that memory.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses: byte-lane extraction, sign/zero extension, and misalignment checking.
- Sub-word stores use a two-cycle read-modify-write, because the memory writes whole words only and its read path returns write data while a write is in progress.

Parameters:
- MEM_AW, 12, byte-address bits forwarded to memory; mem_addr[31:MEM_AW] and mem_addr[1:0] are driven 0.
- OOR_ERR, 1, when 1 a request with any req_addr[31:MEM_AW] bit set is rejected with resp_err.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (size/sign).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse: request completed.
- resp_rdata  out  32  load result (0 for stores and errors).
- resp_err  out  1  misaligned, illegal funct3, or out-of-range request.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data (combinational).

Behaviour:
- States: IDLE, RMW_WR. req_ready = (state==IDLE). A request is accepted on req_valid && req_ready.
- Reset (async): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0; held address/merge registers=0. mem_we is decoded from state and inputs, so it goes 0 immediately when reset asserts.
- Error check at accept:
  - LH/LHU/SH with addr[0]=1 -> err.
  - LW/SW with addr[1:0]!=0 -> err.
  - Load funct3 in {3,6,7} -> err.
  - Store funct3 >=3 -> err.
  - Out-of-range address when OOR_ERR=1 -> err.
  - On err: no memory write, state stays IDLE; next cycle resp_valid=1, resp_err=1, resp_rdata=0.
- Load, accept cycle:
  - mem_we=0; mem_addr={req_addr[MEM_AW-1:2],2'b00}.
  - Select the byte/half lane from mem_rdata using addr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Register the result; next cycle resp_valid=1 with resp_rdata. Latency 1.
- SW, accept cycle: mem_we=1, mem_wdata=req_wdata. Next cycle resp_valid=1, resp_rdata=0. Latency 1; state stays IDLE.
- SB/SH, accept cycle (read phase):
  - mem_we=0.
  - Capture merged = mem_rdata with the addressed lane replaced by req_wdata[7:0] or [15:0]; capture the word address.
  - Go to RMW_WR.
- SB/SH, RMW_WR cycle:
  - mem_we=1, mem_addr=held address, mem_wdata=merged; req_ready=0.
  - Return to IDLE; resp_valid=1 next cycle. Total latency 2, one stall cycle.
- Combinational outputs in IDLE with no accepted request: mem_we=0, mem_addr=0, mem_wdata=0.
- Back-to-back: a new request may be accepted in the cycle resp_valid is high for the previous one. A load immediately after an RMW sees the merged word, because the write completed the cycle before.
- Reset during RMW_WR: the write is abandoned (mem_we=0), state goes to IDLE, no resp_valid is produced.
- resp_err and resp_rdata hold their values until the next completion; consumers qualify them with resp_valid.

Test Plan:
- Preload mem[0x10]=0x88442211. LB 0x13 -> resp_rdata=0xFFFFFF88; LBU 0x13 -> 0x00000088; LH 0x12 -> 0xFFFF8844; LHU 0x10 -> 0x00002211; each with resp_valid exactly 1 cycle after accept.
- SB addr 0x11, wdata 0x000000AB -> req_ready low for 1 cycle; mem_we high only in the 2nd cycle with mem_wdata=0x8844AB11; a following LW 0x10 -> 0x8844AB11.
- SH 0x12, wdata 0x1234CAFE -> word becomes 0xCAFE2211; SW 0x10, wdata 0xDEADBEEF -> mem_we in the accept cycle, word=0xDEADBEEF.
- SH 0x11, LW 0x12, load funct3=3, and SW 0x1000 (MEM_AW=12) -> resp_err=1, resp_rdata=0, mem_we never asserted, memory unchanged.
- Assert rst_n low during RMW_WR of SB 0x11 -> mem_we drops immediately, memory word unchanged, req_ready=1 after reset release, no resp_valid.
- Alternate req_valid every cycle through LW/SB/LW/SH -> responses in request order, no lost or duplicated resp_valid pulses.

Source files
------------

// File: rtl/lsu_subword.sv
`default_nettype none
// ============================================================================
// Module   : lsu_subword
// Purpose  : RV32I load/store front end for a word-only data memory. It does
//            lane select, sign/zero extension, misalignment checks, and a
//            two-cycle read-modify-write for sub-word stores.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_subword #(
  parameter int MEM_AW  = 12,
  parameter bit OOR_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [0:0]  S_IDLE      = 1'b0;
  localparam logic [0:0]  S_RMW_WR    = 1'b1;
  localparam logic [31:0] C_LOW_MASK  = (32'd1 << MEM_AW) - 32'd1;
  localparam logic [31:0] C_WORD_MASK = C_LOW_MASK & 32'hFFFF_FFFC;

  logic [0:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_merged;

  logic        w_accept;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misalign;
  logic        w_bad_f3;
  logic        w_oor;
  logic        w_err;
  logic [31:0] w_word_addr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign req_ready   = (r_state == S_IDLE);
  // rst_n gates acceptance so no write can leak out while reset is held
  assign w_accept    = req_valid && req_ready && rst_n;
  assign w_word_addr = req_addr & C_WORD_MASK;

  assign w_is_half  = (req_funct3[1:0] == 2'b01);
  assign w_is_word  = (req_funct3[1:0] == 2'b10);
  assign w_misalign = (w_is_half && req_addr[0]) || (w_is_word && (req_addr[1:0] != 2'b00));
  assign w_bad_f3   = req_store ? (req_funct3 >= 3'd3)
                                : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
  assign w_oor      = OOR_ERR && ((req_addr & ~C_LOW_MASK) != 32'd0);
  assign w_err      = w_misalign || w_bad_f3 || w_oor;

  always_comb begin
    w_byte = 8'h00;
    case (req_addr[1:0])
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    w_load = 32'd0;
    case (req_funct3)
      3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd2:    w_load = mem_rdata;
      3'd4:    w_load = {24'd0, w_byte};
      3'd5:    w_load = {16'd0, w_half};
      default: w_load = 32'd0;
    endcase
  end

  // Sub-word store: splice the new lane into the word currently in memory
  always_comb begin
    w_merged = mem_rdata;
    if (req_funct3 == 3'd0) begin
      case (req_addr[1:0])
        2'd0:    w_merged[7:0]   = req_wdata[7:0];
        2'd1:    w_merged[15:8]  = req_wdata[7:0];
        2'd2:    w_merged[23:16] = req_wdata[7:0];
        default: w_merged[31:24] = req_wdata[7:0];
      endcase
    end else if (req_addr[1]) begin
      w_merged[31:16] = req_wdata[15:0];
    end else begin
      w_merged[15:0] = req_wdata[15:0];
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (r_state == S_RMW_WR) begin
      mem_we    = rst_n;
      mem_addr  = r_addr;
      mem_wdata = r_merged;
    end else if (w_accept) begin
      mem_addr = w_word_addr;
      if (req_store && !w_err && w_is_word) begin
        mem_we    = 1'b1;
        mem_wdata = req_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= 32'd0;
      r_merged   <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else if (!req_store) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= w_load;
            end else if (w_is_word) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= 32'd0;
            end else begin
              r_addr   <= w_word_addr;
              r_merged <= w_merged;
              r_state  <= S_RMW_WR;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_subword.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_subword
// Purpose  : Directed self-checking bench for lsu_subword with a word memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_subword;

  localparam int MEM_AW = 12;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];

  int n_cmp;
  int n_bad;

  lsu_subword #(.MEM_AW(MEM_AW), .OOR_ERR(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[MEM_AW-1:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[MEM_AW-1:2]] <= mem_wdata;

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
  endtask

  task automatic idle_in();
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
  endtask

  task automatic test_reset();
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 32'd0) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'd0) begin n_bad++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exps [4] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8844, 32'h0000_2211};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(1'b0, f3s[i], adrs[i], 32'd0);
      #1;
      n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL load%0d_mem_we: got %b want 0", i, mem_we); end
      @(posedge clk); #1; idle_in();
      n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL load%0d_valid: got %b want 1", i, resp_valid); end
      n_cmp++; if (resp_rdata !== exps[i]) begin n_bad++; $display("FAIL load%0d_rdata: got %h want %h", i, resp_rdata, exps[i]); end
      n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL load%0d_err: got %b want 0", i, resp_err); end
      @(posedge clk); #1;
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL load%0d_pulse: got %b want 0", i, resp_valid); end
    end
  endtask

  task automatic test_sb_rmw();
    @(negedge clk); drive(1'b1, 3'd0, 32'h11, 32'h0000_00AB);
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL sb_read_we: got %b want 0", mem_we); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL sb_read_ready: got %b want 1", req_ready); end
    @(posedge clk); #1; idle_in();
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL sb_wr_ready: got %b want 0", req_ready); end
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL sb_wr_we: got %b want 1", mem_we); end
    n_cmp++; if (mem_addr !== 32'h10) begin n_bad++; $display("FAIL sb_wr_addr: got %h want 10", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h8844_AB11) begin n_bad++; $display("FAIL sb_wr_data: got %h want 8844ab11", mem_wdata); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL sb_early_valid: got %b want 0", resp_valid); end
    @(posedge clk); #1;
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL sb_valid: got %b want 1", resp_valid); end
    n_cmp++; if (resp_rdata !== 32'd0) begin n_bad++; $display("FAIL sb_rdata: got %h want 0", resp_rdata); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL sb_after_we: got %b want 0", mem_we); end
    n_cmp++; if (mem[4] !== 32'h8844_AB11) begin n_bad++; $display("FAIL sb_mem: got %h want 8844ab11", mem[4]); end
    @(negedge clk); drive(1'b0, 3'd2, 32'h10, 32'd0);
    @(posedge clk); #1; idle_in();
    n_cmp++; if (resp_rdata !== 32'h8844_AB11) begin n_bad++; $display("FAIL sb_lw_rdata: got %h want 8844ab11", resp_rdata); end
  endtask

  task automatic test_sh_sw();
    @(negedge clk); mem[4] = 32'h8844_2211;
    drive(1'b1, 3'd1, 32'h12, 32'h1234_CAFE);
    @(posedge clk); #1; idle_in();
    n_cmp++; if (mem_wdata !== 32'hCAFE_2211) begin n_bad++; $display("FAIL sh_wr_data: got %h want cafe2211", mem_wdata); end
    @(posedge clk); #1;
    n_cmp++; if (mem[4] !== 32'hCAFE_2211) begin n_bad++; $display("FAIL sh_mem: got %h want cafe2211", mem[4]); end
    @(negedge clk); drive(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    #1;
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL sw_we: got %b want 1", mem_we); end
    n_cmp++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_wdata: got %h want deadbeef", mem_wdata); end
    n_cmp++; if (mem_addr !== 32'h10) begin n_bad++; $display("FAIL sw_addr: got %h want 10", mem_addr); end
    @(posedge clk); #1; idle_in();
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL sw_valid: got %b want 1", resp_valid); end
    n_cmp++; if (mem[4] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_mem: got %h want deadbeef", mem[4]); end
  endtask

  task automatic test_errors();
    logic        sts  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s  [5] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd3};
    logic [31:0] adrs [5] = '{32'h11, 32'h12, 32'h10, 32'h1000, 32'h10};
    logic        saw_we;
    for (int i = 0; i < 5; i++) begin
      // a good load first so a stale nonzero rdata would be visible
      @(negedge clk); drive(1'b0, 3'd2, 32'h10, 32'd0);
      @(posedge clk); #1;
      n_cmp++; if (resp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL err%0d_pre_rdata: got %h want deadbeef", i, resp_rdata); end
      @(negedge clk); drive(sts[i], f3s[i], adrs[i], 32'h5555_5555);
      #1; saw_we = mem_we;
      @(posedge clk); #1; idle_in();
      saw_we = saw_we | mem_we;
      n_cmp++; if (saw_we !== 1'b0) begin n_bad++; $display("FAIL err%0d_we: got %b want 0", i, saw_we); end
      n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL err%0d_valid: got %b want 1", i, resp_valid); end
      n_cmp++; if (resp_err !== 1'b1) begin n_bad++; $display("FAIL err%0d_err: got %b want 1", i, resp_err); end
      n_cmp++; if (resp_rdata !== 32'd0) begin n_bad++; $display("FAIL err%0d_rdata: got %h want 0", i, resp_rdata); end
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL err%0d_ready: got %b want 1", i, req_ready); end
    end
    n_cmp++; if (mem[4] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL err_mem4: got %h want deadbeef", mem[4]); end
    n_cmp++; if (mem[0] !== 32'd0) begin n_bad++; $display("FAIL err_mem0: got %h want 0", mem[0]); end
  endtask

  task automatic test_reset_rmw();
    @(negedge clk); mem[4] = 32'h8844_2211;
    drive(1'b1, 3'd0, 32'h11, 32'h0000_00AB);
    @(posedge clk); #1; idle_in();
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rrmw_we_before: got %b want 1", mem_we); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rrmw_we_drop: got %b want 0", mem_we); end
    @(posedge clk); #1;
    n_cmp++; if (mem[4] !== 32'h8844_2211) begin n_bad++; $display("FAIL rrmw_mem: got %h want 88442211", mem[4]); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rrmw_valid%0d: got %b want 0", c, resp_valid); end
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rrmw_ready%0d: got %b want 1", c, req_ready); end
    end
  endtask

  task automatic test_back_to_back();
    logic        sts  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s  [4] = '{3'd2, 3'd0, 3'd2, 3'd1};
    logic [31:0] adrs [4] = '{32'h10, 32'h13, 32'h10, 32'h10};
    logic [31:0] wds  [4] = '{32'd0, 32'h55, 32'd0, 32'h9999};
    logic [31:0] exps [4] = '{32'h8844_2211, 32'd0, 32'h5544_2211, 32'd0};
    logic [31:0] got  [8];
    int n_resp;
    n_resp = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if ((c % 2 == 0) && (c / 2 < 4)) begin
        drive(sts[c/2], f3s[c/2], adrs[c/2], wds[c/2]);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready%0d: got %b want 1", c/2, req_ready); end
      end else begin
        idle_in();
      end
      @(posedge clk); #1;
      if (resp_valid) begin
        if (n_resp < 8) got[n_resp] = resp_rdata;
        n_resp++;
      end
    end
    n_cmp++; if (n_resp !== 4) begin n_bad++; $display("FAIL b2b_count: got %0d want 4", n_resp); end
    for (int i = 0; i < 4; i++) begin
      if (i < n_resp) begin
        n_cmp++; if (got[i] !== exps[i]) begin n_bad++; $display("FAIL b2b_rdata%0d: got %h want %h", i, got[i], exps[i]); end
      end
    end
    n_cmp++; if (mem[4] !== 32'h5544_9999) begin n_bad++; $display("FAIL b2b_mem: got %h want 55449999", mem[4]); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    idle_in();
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[4] = 32'h8844_2211;
    #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_loads();
    test_sb_rmw();
    test_sh_sw();
    test_errors();
    test_reset_rmw();
    @(negedge clk); mem[4] = 32'h8844_2211;
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
